// File: rtl/transmisor_panel.sv
// Panel-side transmitter: synchronises and debounces sensor/button lines, then
// serialises coalesced events as held command bytes on `dato`.
module transmisor_panel #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000,
    parameter logic [7:0]  HOLD       = 8'd8,
    parameter logic [7:0]  GAP        = 8'd4
) (
    input  logic       CLK_tx,
    input  logic       restart,
    input  logic [3:0] sens_raw,
    input  logic       btn_silenciar,
    input  logic       btn_reinicio,
    output logic [7:0] dato,
    output logic       busy,
    output logic       frame_strobe
);

    localparam int              DW      = $clog2(int'(DEB_CYCLES) + 1);
    localparam logic [DW-1:0]   DEB_TOP = DEB_CYCLES[DW-1:0];
    localparam logic [7:0]      CODE_RST = 8'hC0;
    localparam logic [7:0]      CODE_SIL = 8'h80;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    // Bit order: [3:0] sensors, [4] silenciar, [5] reinicio.
    logic [5:0]    sync1, sync2, filt, filt_nxt;
    logic [DW-1:0] deb_cnt [6];
    logic [DW-1:0] deb_cnt_nxt [6];
    logic [2:0]    pend, pend_set, pend_clr;   // {rst, sil, sens}
    state_t        state, state_nxt;
    logic [7:0]    tx_cnt, tx_cnt_nxt, dato_nxt;
    logic          strobe_nxt;

    always_comb begin
        // NOTE: every combinationally written signal gets a default first so no latch is inferred.
        filt_nxt = filt;
        for (int i = 0; i < 6; i++) begin
            deb_cnt_nxt[i] = '0;
            if (sync2[i] != filt[i]) begin
                if (deb_cnt[i] == DEB_TOP - 1'b1) filt_nxt[i] = sync2[i];
                else                              deb_cnt_nxt[i] = deb_cnt[i] + 1'b1;
            end
        end
    end

    assign pend_set = {filt_nxt[5] & ~filt[5],
                       filt_nxt[4] & ~filt[4],
                       |(filt_nxt[3:0] ^ filt[3:0])};

    always_comb begin
        state_nxt  = state;
        dato_nxt   = dato;
        tx_cnt_nxt = tx_cnt;
        strobe_nxt = 1'b0;
        pend_clr   = '0;
        case (state)
            S_IDLE: begin
                dato_nxt = 8'h00;
                if (pend[2]) begin
                    dato_nxt    = CODE_RST;
                    pend_clr[2] = 1'b1;
                end else if (pend[1]) begin
                    dato_nxt    = CODE_SIL;
                    pend_clr[1] = 1'b1;
                end else if (pend[0]) begin
                    dato_nxt    = {4'b0100, filt[3:0]};
                    pend_clr[0] = 1'b1;
                end
                if (|pend) begin
                    strobe_nxt = 1'b1;
                    tx_cnt_nxt = 8'd0;
                    state_nxt  = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_cnt == HOLD - 8'd1) begin
                    dato_nxt   = 8'h00;
                    tx_cnt_nxt = 8'd0;
                    state_nxt  = S_GAP;
                end else begin
                    tx_cnt_nxt = tx_cnt + 8'd1;
                end
            end
            S_GAP: begin
                dato_nxt = 8'h00;
                if (tx_cnt == GAP - 8'd1) begin
                    tx_cnt_nxt = 8'd0;
                    state_nxt  = S_IDLE;
                end else begin
                    tx_cnt_nxt = tx_cnt + 8'd1;
                end
            end
            default: begin
                dato_nxt  = 8'h00;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLK_tx or negedge restart) begin
        if (!restart) begin
            sync1        <= '0;
            sync2        <= '0;
            filt         <= '0;
            // NOTE: the small counter array is reset explicitly; filtering must restart from a known count.
            for (int i = 0; i < 6; i++) deb_cnt[i] <= '0;
            pend         <= '0;
            state        <= S_IDLE;
            tx_cnt       <= 8'd0;
            dato         <= 8'h00;
            frame_strobe <= 1'b0;
        end else begin
            sync1        <= {btn_reinicio, btn_silenciar, sens_raw};
            sync2        <= sync1;
            filt         <= filt_nxt;
            for (int i = 0; i < 6; i++) deb_cnt[i] <= deb_cnt_nxt[i];
            // A set on the same edge as its dispatch clear wins, so no event is lost.
            pend         <= (pend & ~pend_clr) | pend_set;
            state        <= state_nxt;
            tx_cnt       <= tx_cnt_nxt;
            dato         <= dato_nxt;
            frame_strobe <= strobe_nxt;
        end
    end

    assign busy = (state == S_SEND) || (state == S_GAP);

endmodule

// File: tb/tb_transmisor_panel.sv
// Scoreboard bench for transmisor_panel with DEB_CYCLES=4, HOLD=3, GAP=2.
module tb_transmisor_panel;

    localparam int DEB  = 4;
    localparam int HOLD = 3;
    localparam int GAP  = 2;
    localparam int LAT  = DEB + 3;

    logic       clk = 1'b0;
    logic       restart = 1'b0;
    logic [3:0] sens_raw = 4'h0;
    logic       btn_silenciar = 1'b0;
    logic       btn_reinicio = 1'b0;
    logic [7:0] dato;
    logic       busy;
    logic       frame_strobe;

    typedef struct {
        logic [7:0] code;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] prev_dato = 8'h00;
    int   run_len = 0;

    transmisor_panel #(
        .DEB_CYCLES(16'(DEB)),
        .HOLD      (8'(HOLD)),
        .GAP       (8'(GAP))
    ) dut (
        .CLK_tx       (clk),
        .restart      (restart),
        .sens_raw     (sens_raw),
        .btn_silenciar(btn_silenciar),
        .btn_reinicio (btn_reinicio),
        .dato         (dato),
        .busy         (busy),
        .frame_strobe (frame_strobe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Frame monitor: pops the scoreboard on each strobe and checks frame shape.
    always @(negedge clk) begin
        if (!restart) begin
            prev_dato = 8'h00;
            run_len   = 0;
        end else begin
            logic exp_strb;
            if (frame_strobe) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame cyc=%0d dato=%h required no frame", cyc, dato);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (dato !== e.code || (e.cyc >= 0 && cyc != e.cyc)) begin
                        errors++;
                        $display("FAIL frame dato=%h cyc=%0d required dato=%h cyc=%0d", dato, cyc, e.code, e.cyc);
                    end
                end
            end
            exp_strb = (dato != 8'h00) && (prev_dato == 8'h00);
            if (frame_strobe || exp_strb) begin
                checks++;
                if (frame_strobe !== exp_strb) begin
                    errors++;
                    $display("FAIL strobe_edge cyc=%0d strobe=%b required %b", cyc, frame_strobe, exp_strb);
                end
            end
            if (dato != 8'h00 && prev_dato != 8'h00 && dato != prev_dato) begin
                checks++;
                errors++;
                $display("FAIL dato_stable cyc=%0d dato=%h required %h", cyc, dato, prev_dato);
            end
            if (dato != 8'h00) begin
                run_len++;
            end else if (prev_dato != 8'h00) begin
                checks++;
                if (run_len != HOLD) begin
                    errors++;
                    $display("FAIL hold_len cyc=%0d len=%0d required %0d", cyc, run_len, HOLD);
                end
                run_len = 0;
            end
            prev_dato = dato;
        end
    end

    task automatic expect_frame(input logic [7:0] code, input int at);
        exp_t e;
        e.code = code;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0 || busy) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d busy=%b required 0 0", name, sb.size(), busy);
            sb.delete();
        end
        repeat (LAT + 4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover pending=%0d required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (dato !== 8'h00 || busy !== 1'b0 || frame_strobe !== 1'b0) begin
            errors++;
            $display("FAIL reset dato=%h busy=%b strobe=%b required 00 0 0", dato, busy, frame_strobe);
        end
        restart = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_sensor_frame();
        int n;
        @(negedge clk);
        sens_raw[1] = 1'b1;
        n = cyc;
        expect_frame(8'h42, n + LAT);
        while (cyc < n + LAT) @(negedge clk);
        for (int k = 0; k < HOLD + GAP + 1; k++) begin
            checks++;
            if (busy !== (k < HOLD + GAP)) begin
                errors++;
                $display("FAIL busy_window cyc=%0d busy=%b required %b", cyc, busy, k < HOLD + GAP);
            end
            @(negedge clk);
        end
        wait_done("gas_on", 40);
        sens_raw[1] = 1'b0;
        n = cyc;
        expect_frame(8'h40, n + LAT);
        wait_done("gas_off", 40);
    endtask

    task automatic test_glitch();
        logic saw_busy = 1'b0;
        sens_raw[2] = 1'b1;
        repeat (DEB - 1) @(negedge clk);
        sens_raw[2] = 1'b0;
        repeat (20) begin
            @(negedge clk);
            saw_busy |= busy;
        end
        checks++;
        if (saw_busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy busy=%b required 0", saw_busy);
        end
    endtask

    task automatic test_priority();
        int n;
        btn_silenciar = 1'b1;
        btn_reinicio  = 1'b1;
        n = cyc;
        expect_frame(8'hC0, n + LAT);
        expect_frame(8'h80, n + LAT + HOLD + GAP + 1);
        wait_done("priority", 60);
        btn_reinicio = 1'b0;
        wait_done("release_rst", 30);
    endtask

    task automatic test_coalesce();
        int n;
        btn_silenciar = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        btn_silenciar = 1'b1;
        n = cyc;
        expect_frame(8'h80, n + LAT);
        expect_frame(8'h49, n + LAT + HOLD + GAP + 1);
        repeat (2) @(negedge clk);
        sens_raw[0] = 1'b1;
        @(negedge clk);
        sens_raw[3] = 1'b1;
        wait_done("coalesce", 60);
        btn_silenciar = 1'b0;
        wait_done("release_sil", 30);
    endtask

    task automatic test_reset_mid_frame();
        int n;
        @(negedge clk);
        btn_reinicio = 1'b1;
        n = cyc;
        expect_frame(8'hC0, n + LAT);
        @(negedge clk);
        sens_raw[0] = 1'b0;
        while (cyc < n + LAT + 1) @(negedge clk);
        #2 restart = 1'b0;
        #1;
        checks++;
        if (dato !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset dato=%h busy=%b required 00 0", dato, busy);
        end
        sens_raw      = 4'h0;
        btn_reinicio  = 1'b0;
        btn_silenciar = 1'b0;
        repeat (3) @(negedge clk);
        restart = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || dato !== 8'h00 || sb.size() != 0) begin
            errors++;
            $display("FAIL post_reset busy=%b dato=%h pending=%0d required 0 00 0", busy, dato, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_long_press();
        int n;
        @(negedge clk);
        btn_reinicio = 1'b1;
        n = cyc;
        expect_frame(8'hC0, n + LAT);
        repeat (50) @(negedge clk);
        btn_reinicio = 1'b0;
        wait_done("long_press", 40);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d required finish before limit", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sensor_frame();
        test_glitch();
        test_priority();
        test_coalesce();
        test_reset_mid_frame();
        test_long_press();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/transmisor_panel.md
Name: transmisor_panel

Overview:
- Panel-side source of the 8-bit `dato` command byte consumed by the alarm's reception block.
- Synchronises and debounces the four raw sensor lines (corto, gas, humo, temp) and the two panel buttons (silenciar, reinicio).
- Encodes each filtered event into a one-byte frame and presents it on `dato` for a fixed hold time, followed by an idle gap.
- Events arriving while a frame is in flight are queued and coalesced, so no state change is lost.

Parameters:
- DEB_CYCLES, 16'd50000: consecutive stable cycles required before a filtered input changes (≥1).
- HOLD, 8'd8: cycles a frame byte is held on `dato` (≥1).
- GAP, 8'd4: cycles of 0x00 driven after each frame (≥1).

Ports:
- CLK_tx  in  1  system clock; all logic on rising edge.
- restart  in  1  asynchronous, active-low reset.
- sens_raw  in  4  raw sensors: [0] corto, [1] gas, [2] humo, [3] temp. Asynchronous.
- btn_silenciar  in  1  raw silence button, active-high. Asynchronous.
- btn_reinicio  in  1  raw system-restart button, active-high. Asynchronous.
- dato  out  8  encoded byte to the receiver; 0x00 = idle.
- busy  out  1  high while the FSM is in SEND or GAP.
- frame_strobe  out  1  one-cycle pulse on the first cycle a new frame appears on `dato`.

Behaviour:
- Reset (restart=0, asynchronous):
  - dato=0x00, busy=0, frame_strobe=0.
  - Sync flops, filtered states and debounce counters = 0.
  - All pending flags cleared; FSM in IDLE.
  - Asserting reset mid-frame drops `dato` to 0x00 immediately and discards any pending events.
- Synchronisation: each of the 6 raw inputs passes a 2-FF synchroniser.
- Debounce, per input:
  - The counter clears whenever the synced value equals the filtered value.
  - Otherwise the counter increments.
  - On the edge where it reaches DEB_CYCLES, the filtered value takes the synced value and the counter clears.
  - Pulses shorter than DEB_CYCLES synced cycles never change the filtered value.
- Event detection, registered on the same edge the filtered value changes:
  - Any filtered sensor bit changing → set pend_sens.
  - Filtered btn_silenciar 0→1 → set pend_sil.
  - Filtered btn_reinicio 0→1 → set pend_rst.
  - Button releases generate no event.
  - A pending flag that is already set stays set: repeated events coalesce into one frame.
- Frame encoding:
  - Reset frame: 0xC0.
  - Silence frame: 0x80.
  - Sensor frame: {2'b01, 2'b00, sens_filt[3:0]}, i.e. 0x40–0x4F. It carries the filtered sensor value sampled at SEND entry, not at event time.
- FSM, with states IDLE, SEND and GAP:
  - IDLE: dato=0x00, busy=0. If any pending flag is set, select by priority pend_rst > pend_sil > pend_sens. Next edge: dato = selected code, frame_strobe=1, selected flag cleared, hold counter=0, go to SEND.
  - SEND: dato held constant, busy=1. Stay for HOLD cycles total, then dato=0x00 and go to GAP.
  - GAP: dato=0x00, busy=1. Stay GAP cycles, then go to IDLE. IDLE with a flag still pending dispatches on the following edge.
  - Minimum frame spacing is therefore HOLD+GAP+1 cycles.
- Latency: a raw level change that stays stable changes `dato` DEB_CYCLES+3 cycles after the raw edge when the FSM is IDLE. The breakdown is 2 cycles sync, DEB_CYCLES cycles debounce, 1 cycle FSM dispatch.
- Simultaneous events:
  - Events setting several flags in one cycle are all retained and sent in priority order.
  - An event arriving on the same edge its flag is being cleared by dispatch is retained, because set wins over clear.
- Sensor changes during SEND/GAP:
  - Only the latest filtered value is sent.
  - A sensor that toggles and returns before dispatch still yields one frame carrying the current value.
- Widths:
  - The debounce counter is sized to hold DEB_CYCLES.
  - The hold and gap counters are 8 bits and never wrap, since they terminate at HOLD/GAP.

Test Plan (DEB_CYCLES=4, HOLD=3, GAP=2):
1. Release reset; gas raw 0→1 at cycle 10, held. Required: dato=0x42 from cycle 17 for 3 cycles; frame_strobe=1 at cycle 17 only; busy=1 over cycles 17–21; dato=0x00 thereafter.
2. humo raw high for 3 cycles, then low. Required: dato stays 0x00, frame_strobe never pulses, busy stays 0.
3. btn_silenciar and btn_reinicio rise in the same cycle. Required: 0xC0 (3 cycles), 0x00 (2 cycles), 1 cycle IDLE, then 0x80 (3 cycles); two frame_strobe pulses 6 cycles apart.
4. During a 0x80 frame, corto rises then temp rises (both debounced before GAP ends). Required: exactly one following frame, 0x49; no intermediate 0x41.
5. Assert restart mid-SEND of 0xC0. Required: dato=0x00 and busy=0 asynchronously. After release with inputs held low, no frame is sent.
6. Hold btn_reinicio high for 50 cycles. Required: exactly one 0xC0 frame; release generates nothing.
